// File: rtl/bht_ctrl_pkg.sv
// Shared types and sizing helpers for the BHT update scheduler.
package bht_ctrl_pkg;

    localparam int unsigned PC_W           = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 5;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } bht_upd_t;

    typedef enum logic {S_CLEAR, S_RUN} bht_ctrl_state_e;

    // Counter width able to index n values; never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bht_ctrl_if.sv
// Update requesters, BHT write port and status of the BHT update scheduler.
interface bht_ctrl_if;
    import bht_ctrl_pkg::*;

    logic            flush_i;
    logic            upd0_valid_i;
    logic            upd0_ready_o;
    logic [PC_W-1:0] upd0_pc_i;
    logic            upd0_taken_i;
    logic            upd1_valid_i;
    logic            upd1_ready_o;
    logic [PC_W-1:0] upd1_pc_i;
    logic            upd1_taken_i;
    logic            bht_we_o;
    logic [PC_W-1:0] bht_wpc_o;
    logic            bht_taken_o;
    logic            busy_o;

    modport slave (
        input  flush_i,
        input  upd0_valid_i, upd0_pc_i, upd0_taken_i,
        input  upd1_valid_i, upd1_pc_i, upd1_taken_i,
        output upd0_ready_o, upd1_ready_o,
        output bht_we_o, bht_wpc_o, bht_taken_o, busy_o
    );

    modport master (
        output flush_i,
        output upd0_valid_i, upd0_pc_i, upd0_taken_i,
        output upd1_valid_i, upd1_pc_i, upd1_taken_i,
        input  upd0_ready_o, upd1_ready_o,
        input  bht_we_o, bht_wpc_o, bht_taken_o, busy_o
    );

endinterface

// File: rtl/bht_upd_fifo.sv
// Two-write/one-read FIFO of BHT updates; write port 0 lands ahead of port 1.
module bht_upd_fifo
    import bht_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned PTR_W = width_of(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push0_i,
    input  logic             push1_i,
    input  bht_upd_t         data0_i,
    input  bht_upd_t         data1_i,
    input  logic             pop_i,
    output bht_upd_t         head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] free_o
);

    bht_upd_t         mem_q [DEPTH];
    bht_upd_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push0_i) begin
                mem_d[wr_ptr_d] = data0_i;
                wr_ptr_d        = wr_ptr_d + PTR_W'(1);
            end
            if (push1_i) begin
                mem_d[wr_ptr_d] = data1_i;
                wr_ptr_d        = wr_ptr_d + PTR_W'(1);
            end
            if (pop_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign free_o  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/bht_ctrl.sv
// BHT update scheduler: zero-clears every history after reset/flush, then serialises
// two-pipe updates into the single BHT write port. BHT_CTRL_BYPASS_EN adds pipe0 bypass.
module bht_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic         clk,
    input logic         rst_n,
    bht_ctrl_if.slave   bus
);

    localparam int unsigned SHIFT_W = width_of(DATA_WIDTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PAD_W   = PC_W - ADDR_WIDTH - 3;

    bht_ctrl_state_e    state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;

    bht_upd_t         upd0, upd1, head;
    logic             fifo_clr, push0, push1, pop, empty;
    logic [CNT_W-1:0] free;
    logic             acc0, acc1, byp;
    logic             we_c, taken_c, ready0_c, ready1_c, busy_c;
    logic [PC_W-1:0]  wpc_c;

    assign upd0 = '{pc: bus.upd0_pc_i, taken: bus.upd0_taken_i};
    assign upd1 = '{pc: bus.upd1_pc_i, taken: bus.upd1_taken_i};

    bht_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifo_clr),
        .push0_i (push0),
        .push1_i (push1),
        .data0_i (upd0),
        .data1_i (upd1),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .free_o  (free)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        we_c     = 1'b0;
        wpc_c    = '0;
        taken_c  = 1'b0;
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        busy_c   = 1'b1;
        fifo_clr = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        pop      = 1'b0;
        acc0     = 1'b0;
        acc1     = 1'b0;
        byp      = 1'b0;
        if (rst_n) begin
            fifo_clr = bus.flush_i;
            case (state_q)
                S_CLEAR: begin
                    we_c  = 1'b1;
                    wpc_c = {{PAD_W{1'b0}}, idx_q, 3'b000};
                    if (bus.flush_i) begin
                        idx_d   = '0;
                        shift_d = '0;
                    end else if (shift_q == SHIFT_W'(DATA_WIDTH - 1)) begin
                        shift_d = '0;
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        if (idx_q == {ADDR_WIDTH{1'b1}}) state_d = S_RUN;
                    end else begin
                        shift_d = shift_q + SHIFT_W'(1);
                    end
                end
                S_RUN: begin
                    busy_c = 1'b0;
                    if (bus.flush_i) begin
                        state_d = S_CLEAR;
                        idx_d   = '0;
                        shift_d = '0;
                    end else begin
                        ready0_c = (free >= CNT_W'(1));
                        ready1_c = (free >= CNT_W'(2));
                        acc0     = bus.upd0_valid_i & ready0_c;
                        acc1     = bus.upd1_valid_i & ready1_c;
`ifdef BHT_CTRL_BYPASS_EN
                        byp      = empty & acc0;
`endif
                        push1 = acc1;
                        if (byp) begin
                            we_c    = 1'b1;
                            wpc_c   = upd0.pc;
                            taken_c = upd0.taken;
                        end else begin
                            push0 = acc0;
                            if (!empty) begin
                                we_c    = 1'b1;
                                wpc_c   = head.pc;
                                taken_c = head.taken;
                                pop     = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign bus.bht_we_o     = we_c;
    assign bus.bht_wpc_o    = wpc_c;
    assign bus.bht_taken_o  = taken_c;
    assign bus.upd0_ready_o = ready0_c;
    assign bus.upd1_ready_o = ready1_c;
    assign bus.busy_o       = busy_c;

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl with a queue-based reference model checked every cycle.
module tb_bht_ctrl;
    import bht_ctrl_pkg::*;

    localparam int DW          = 5;
    localparam int DEPTH       = 4;
    localparam int CLEAR_TOTAL = 1024 * DW;

`ifdef BHT_CTRL_BYPASS_EN
    localparam int          N4     = 7;
    localparam logic [31:0] X4_PC [7] = '{32'h1000, 32'h2000, 32'h1010, 32'h2010,
                                          32'h1020, 32'h2020, 32'h1030};
    localparam logic        X4_T  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0]  X4_R1 = 4'b0111;
    localparam int          N5     = 4;
    localparam logic [31:0] X5_PC [4] = '{32'h3000, 32'h4000, 32'h3010, 32'h4010};
`else
    localparam int          N4     = 6;
    localparam logic [31:0] X4_PC [6] = '{32'h1000, 32'h2000, 32'h1010, 32'h2010,
                                          32'h1020, 32'h1030};
    localparam logic        X4_T  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [3:0]  X4_R1 = 4'b0011;
    localparam int          N5     = 3;
    localparam logic [31:0] X5_PC [3] = '{32'h3000, 32'h4000, 32'h3010};
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bht_ctrl_if bus ();

    bht_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    bit       clearing = 1'b1;
    int       clear_k  = 0;
    bht_upd_t mq[$];
    bht_upd_t wlog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: clear walk as a write counter, RUN as an in-order queue.
    always @(negedge clk) begin : model
        logic        e_we, e_r0, e_r1, e_busy, e_t;
        logic [31:0] e_pc;
        bit          a0, a1, byp;
        int          fr;
        e_we = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_busy = 1'b1; e_t = 1'b0; e_pc = '0;
        byp = 1'b0;
        if (!rst_n) begin
            clearing = 1'b1;
            clear_k  = 0;
            mq.delete();
        end else if (clearing) begin
            e_we = 1'b1;
            e_pc = 32'((clear_k / DW) * 8);
            if (bus.flush_i) clear_k = 0;
            else begin
                clear_k++;
                if (clear_k == CLEAR_TOTAL) clearing = 1'b0;
            end
        end else begin
            e_busy = 1'b0;
            fr = DEPTH - mq.size();
            if (bus.flush_i) begin
                mq.delete();
                clearing = 1'b1;
                clear_k  = 0;
            end else begin
                e_r0 = (fr >= 1);
                e_r1 = (fr >= 2);
                a0 = bus.upd0_valid_i && e_r0;
                a1 = bus.upd1_valid_i && e_r1;
`ifdef BHT_CTRL_BYPASS_EN
                byp = (mq.size() == 0) && a0;
`endif
                if (byp) begin
                    e_we = 1'b1; e_pc = bus.upd0_pc_i; e_t = bus.upd0_taken_i;
                end else if (mq.size() > 0) begin
                    e_we = 1'b1; e_pc = mq[0].pc; e_t = mq[0].taken;
                    void'(mq.pop_front());
                end
                if (a0 && !byp) mq.push_back('{pc: bus.upd0_pc_i, taken: bus.upd0_taken_i});
                if (a1)         mq.push_back('{pc: bus.upd1_pc_i, taken: bus.upd1_taken_i});
            end
        end
        chk("we", 32'(bus.bht_we_o), 32'(e_we));
        chk("ready0", 32'(bus.upd0_ready_o), 32'(e_r0));
        chk("ready1", 32'(bus.upd1_ready_o), 32'(e_r1));
        chk("busy", 32'(bus.busy_o), 32'(e_busy));
        if (rst_n) begin
            chk("wpc", bus.bht_wpc_o, e_pc);
            chk("wtaken", 32'(bus.bht_taken_o), 32'(e_t));
            if (!e_busy && bus.bht_we_o)
                wlog.push_back('{pc: bus.bht_wpc_o, taken: bus.bht_taken_o});
        end
    end

    task automatic clear_walk(output int n, output logic [31:0] first, output logic [31:0] last,
                              output bit done);
        n = 0; done = 1'b0; first = '1; last = '1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!bus.busy_o) begin
                done = 1'b1;
                break;
            end
            if (bus.bht_we_o) begin
                if (n == 0) first = bus.bht_wpc_o;
                last = bus.bht_wpc_o;
                n++;
            end
        end
    endtask

    task automatic log_chk(input string nm, input int i, input logic [31:0] pc, input logic t,
                           input bit check_t);
        bht_upd_t e;
        e = (i < wlog.size()) ? wlog[i] : '{pc: 32'hFFFF_FFFF, taken: 1'b0};
        chk(nm, e.pc, pc);
        if (check_t) chk(nm, 32'(e.taken), 32'(t));
    endtask

    task automatic burst(input logic [31:0] b0, input logic [31:0] b1,
                         output logic [3:0] r0, output logic [3:0] r1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.upd0_valid_i = 1'b1; bus.upd0_pc_i = b0 + 32'(c * 16); bus.upd0_taken_i = c[0];
            bus.upd1_valid_i = 1'b1; bus.upd1_pc_i = b1 + 32'(c * 16); bus.upd1_taken_i = 1'b1;
            @(negedge clk);
            r0[c] = bus.upd0_ready_o;
            r1[c] = bus.upd1_ready_o;
        end
    endtask

    task automatic idle_inputs();
        bus.upd0_valid_i = 1'b0; bus.upd1_valid_i = 1'b0;
        bus.upd0_taken_i = 1'b0; bus.upd1_taken_i = 1'b0;
        bus.upd0_pc_i = '0; bus.upd1_pc_i = '0;
    endtask

    initial begin
        int          n;
        logic [31:0] first, last;
        bit          done;
        logic [3:0]  r0, r1;

        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'd1);
        chk("rst_we", 32'(bus.bht_we_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Initial clear walk.
        clear_walk(n, first, last, done);
        chk("clr_count", 32'(n), 32'd5120);
        chk("clr_first", first, 32'h0);
        chk("clr_last", last, 32'h1FF8);
        chk("clr_done", 32'(done), 32'd1);
        chk("idle_r0", 32'(bus.upd0_ready_o), 32'd1);
        chk("idle_r1", 32'(bus.upd1_ready_o), 32'd1);

        // Single pipe0 update latency.
        @(posedge clk); #1;
        bus.upd0_valid_i = 1'b1; bus.upd0_pc_i = 32'h1C00_0010; bus.upd0_taken_i = 1'b1;
        @(negedge clk);
`ifdef BHT_CTRL_BYPASS_EN
        chk("lat_we0", 32'(bus.bht_we_o), 32'd1);
        chk("lat_pc0", bus.bht_wpc_o, 32'h1C00_0010);
`else
        chk("lat_we0", 32'(bus.bht_we_o), 32'd0);
`endif
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
`ifdef BHT_CTRL_BYPASS_EN
        chk("lat_we1", 32'(bus.bht_we_o), 32'd0);
`else
        chk("lat_we1", 32'(bus.bht_we_o), 32'd1);
        chk("lat_pc1", bus.bht_wpc_o, 32'h1C00_0010);
        chk("lat_t1", 32'(bus.bht_taken_o), 32'd1);
`endif
        @(negedge clk);
        chk("lat_we2", 32'(bus.bht_we_o), 32'd0);

        // Dual-pipe single cycle: pipe0 written first.
        wlog.delete();
        @(posedge clk); #1;
        bus.upd0_valid_i = 1'b1; bus.upd0_pc_i = 32'h100; bus.upd0_taken_i = 1'b0;
        bus.upd1_valid_i = 1'b1; bus.upd1_pc_i = 32'h108; bus.upd1_taken_i = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(negedge clk);
        chk("dual_n", 32'(wlog.size()), 32'd2);
        log_chk("dual_w0", 0, 32'h100, 1'b0, 1'b1);
        log_chk("dual_w1", 1, 32'h108, 1'b1, 1'b1);

        // Back-to-back dual bursts: ready1 throttles, order preserved.
        wlog.delete();
        burst(32'h1000, 32'h2000, r0, r1);
        @(posedge clk); #1;
        idle_inputs();
        repeat (8) @(negedge clk);
        chk("burst_r0", 32'(r0), 32'hF);
        chk("burst_r1", 32'(r1), 32'(X4_R1));
        chk("burst_n", 32'(wlog.size()), 32'(N4));
        for (int i = 0; i < N4; i++) log_chk("burst_w", i, X4_PC[i], X4_T[i], 1'b1);

        // Flush with three entries queued.
        wlog.delete();
        burst(32'h3000, 32'h4000, r0, r1);
        @(posedge clk); #1;
        idle_inputs();
        bus.upd0_valid_i = 1'b1; bus.upd0_pc_i = 32'h5000;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_r0", 32'(bus.upd0_ready_o), 32'd0);
        chk("flush_we", 32'(bus.bht_we_o), 32'd0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        clear_walk(n, first, last, done);
        chk("reclr_count", 32'(n), 32'd5120);
        chk("reclr_first", first, 32'h0);
        chk("reclr_done", 32'(done), 32'd1);
        bus.upd0_valid_i = 1'b0;
        chk("flush_n", 32'(wlog.size()), 32'(N5));
        for (int i = 0; i < N5; i++) log_chk("flush_w", i, X5_PC[i], 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
Name: bht_ctrl

Overview:
Update scheduler and initialiser for the single-write-port branch history table (BHT). It accepts branch-resolution updates from two requesters (EX pipes 0/1). It buffers them in a small FIFO and serialises them into the BHT write port, one per cycle. After reset or flush it walks every BHT entry, shifting in DATA_WIDTH zeros, so all histories read 0. Sits between the branch-resolve stages and the BHT inside the BPU.

Parameters:
ADDR_WIDTH, 10, BHT index width; index = pc[ADDR_WIDTH+2:3]
DATA_WIDTH, 5, BHT history width; number of zero-shifts needed to clear one entry
FIFO_DEPTH, 4, update buffer entries; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush_i  in  1  request full BHT re-clear; pending updates discarded
upd0_valid_i  in  1  pipe0 update valid
upd0_ready_o  out  1  pipe0 update accepted when valid&ready
upd0_pc_i  in  32  pipe0 branch pc
upd0_taken_i  in  1  pipe0 resolved direction
upd1_valid_i  in  1  pipe1 update valid
upd1_ready_o  out  1  pipe1 update accepted when valid&ready
upd1_pc_i  in  32  pipe1 branch pc
upd1_taken_i  in  1  pipe1 resolved direction
bht_we_o  out  1  BHT write enable
bht_wpc_o  out  32  BHT write pc
bht_taken_o  out  1  bit shifted into selected history
busy_o  out  1  1 while clearing

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, idx=0, shift=0, state=CLEAR. While reset is asserted, ready0/1=0, busy_o=1, bht_we_o=0.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle bht_we_o=1, bht_wpc_o={zeros, idx, 3'b000}, bht_taken_o=0.
  - shift counts 0..DATA_WIDTH-1. On wrap, shift=0 and idx+1.
  - When idx=2^ADDR_WIDTH-1 and shift=DATA_WIDTH-1, go to RUN next cycle.
  - Total (2^ADDR_WIDTH)*DATA_WIDTH write cycles; 5120 with defaults.
  - ready0/1=0, busy_o=1.
- RUN:
  - ready0 = free>=1; ready1 = free>=2. Both are independent of valid.
  - Same-cycle accept: pipe0 is enqueued ahead of pipe1.
  - Drain: if FIFO non-empty, bht_we_o=1, and bht_wpc_o/bht_taken_o are taken combinationally from the head; pop at the same edge. Otherwise bht_we_o=0 and bht_wpc_o/bht_taken_o=0.
  - An update accepted at edge N is written at edge N+1 if the FIFO was empty.
  - Simultaneous push and pop in one cycle are allowed; free counts the pop.
- Order: updates are written in acceptance order. Same-pc updates are never merged; each one shifts.
- flush_i=1 at posedge (either state):
  - FIFO emptied, idx=0, shift=0, state=CLEAR.
  - Updates presented in that cycle are not accepted; ready is low that cycle, driven combinationally from flush_i.
  - Flush during CLEAR restarts the walk.
- Reset has priority over flush. Reset mid-clear restarts the walk from idx 0.
- FIFO full: ready0=0. With one slot free: ready1=0 and ready0=1.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
BHT_CTRL_BYPASS_EN
- Defined, in RUN with the FIFO empty and upd0 valid&ready (flush_i=0): the pipe0 update drives bht_we_o/bht_wpc_o/bht_taken_o in the same cycle (zero latency) and is not enqueued. A simultaneous pipe1 update is enqueued and written the next cycle.
- Undefined: no bypass; all updates pass through the FIFO with one cycle of latency.

Decomposition:
- Package bht_ctrl_pkg:
  - typedef bht_upd_t {logic [31:0] pc; logic taken;}
  - enum bht_ctrl_state_e {S_CLEAR, S_RUN}
  - localparam helpers for counter widths
- Sub-module bht_upd_fifo: 2-write/1-read FIFO of bht_upd_t with free-count output.

Test Plan:
- Reset release, no traffic: bht_we_o=1 for exactly 5120 cycles. First write wpc=0x0, last wpc=0x1FF8, each pc written 5 times, taken=0. busy_o drops on cycle 5120.
- RUN, pipe0 pc=0x1C00_0010 taken=1 single cycle: next cycle bht_we_o=1, bht_wpc_o=0x1C00_0010, bht_taken_o=1. The following cycle bht_we_o=0.
- Both pipes valid one cycle, pc0=0x100 t=0, pc1=0x108 t=1: writes appear 0x100/0 then 0x108/1 on consecutive cycles.
- Hold the FIFO by issuing 4 dual-pipe requests back-to-back: ready1 drops when free<2 and ready0 drops at full. No update is lost or reordered; the written sequence equals the accepted sequence.
- flush_i with 3 entries queued: the queued entries are never written. The clear walk restarts at wpc=0, and ready is 0 for 5120 cycles.
- With BHT_CTRL_BYPASS_EN, empty FIFO, pipe0 pc=0x200 t=1: bht_we_o=1 with wpc=0x200 in the same cycle. Without the macro it appears one cycle later.
